// File: rtl/ram_io_pkg.sv
// rtl/ram_io_pkg.sv - shared encodings, IO addresses and read-extension helper for ram_io
package ram_io_pkg;

    typedef enum logic [1:0] {
        WT_NONE = 2'b00,
        WT_BYTE = 2'b01,
        WT_HALF = 2'b10,
        WT_WORD = 2'b11
    } write_type_e;

    localparam logic [2:0] RT_NONE   = 3'b000;
    localparam logic [1:0] RT_BYTE   = 2'b01;
    localparam logic [1:0] RT_HALF   = 2'b10;
    localparam logic [1:0] RT_WORD   = 2'b11;
    localparam int         RT_SIGNED = 2;

    localparam logic [31:0] ADDR_LED     = 32'hFFFF_FFFF;
    localparam logic [31:0] ADDR_UART_TX = 32'hFFFF_FFFE;

    // Right-aligned value in, zero/sign extended per the read size and sign bit.
    function automatic logic [31:0] extend_rd(input logic [31:0] v, input logic [2:0] rt);
        case (rt[1:0])
            RT_BYTE: return {{24{rt[RT_SIGNED] & v[7]}}, v[7:0]};
            RT_HALF: return {{16{rt[RT_SIGNED] & v[15]}}, v[15:0]};
            default: return v;
        endcase
    endfunction

endpackage

// File: rtl/ram_io_uart_tx.sv
// rtl/ram_io_uart_tx.sv - 8N1 UART transmitter, busy from the cycle after go until the stop bit ends
module ram_io_uart_tx #(
    parameter int CLK_FREQ  = 27_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       go,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy
);

    localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
    localparam int CW = $clog2(BIT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e        state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            tx    <= 1'b1;
            busy  <= 1'b0;
        end else if (state == IDLE) begin
            if (go) begin
                state <= START;
                shreg <= data;
                cnt   <= '0;
                tx    <= 1'b0;
                busy  <= 1'b1;
            end
        end else if (cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
            case (state)
                START: begin
                    state <= DATA;
                    idx   <= '0;
                    tx    <= shreg[0];
                end
                DATA: begin
                    if (idx == 3'd7) begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end else begin
                        idx   <= idx + 3'd1;
                        tx    <= shreg[1];
                        shreg <= shreg >> 1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ram_io.sv
// rtl/ram_io.sv - memory/IO stage: byte-lane block RAM, LED register and UART tx window
module ram_io
    import ram_io_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 12,
    parameter int CLK_FREQ       = 27_000_000,
    parameter int BAUD_RATE      = 115200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [1:0]  write_type,
    input  logic [2:0]  read_type,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        data_out_ready,
    output logic        busy,
    output logic [5:0]  led,
    output logic        uart_tx
);

    localparam int DEPTH = 2 ** RAM_ADDR_WIDTH;

    logic                      capture, is_wr, is_rd, is_io, is_led, is_uart;
    logic                      uart_busy, uart_go;
    logic [RAM_ADDR_WIDTH-1:0] widx;
    logic [3:0]                lane_we;
    logic [31:0]               wdata, rd_word, raw;
    logic                      valid_q;
    logic [31:0]               addr_q;
    logic [2:0]                type_q;

    assign busy    = uart_busy;
    assign capture = enable & ~uart_busy;
    assign is_wr   = write_type != WT_NONE;
    assign is_rd   = !is_wr && (read_type != RT_NONE);
    assign is_io   = address[31:4] == 28'hFFF_FFFF;
    assign is_led  = address == ADDR_LED;
    assign is_uart = address == ADDR_UART_TX;
    assign widx    = address[RAM_ADDR_WIDTH+1:2];
    assign uart_go = capture && (write_type == WT_BYTE) && is_uart;

    always_comb begin
        lane_we = '0;
        wdata   = data_in;
        case (write_type)
            WT_BYTE: begin
                lane_we = 4'b0001 << address[1:0];
                wdata   = {4{data_in[7:0]}};
            end
            WT_HALF: begin
                lane_we = address[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{data_in[15:0]}};
            end
            WT_WORD: lane_we = 4'b1111;
            default: lane_we = '0;
        endcase
        if (!capture || is_io)
            lane_we = '0;
    end

    // Reads are launched on every capture; only valid_q decides whether the result is used.
    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] rd_q;
        always_ff @(posedge clk) begin
            if (lane_we[g])
                mem[widx] <= wdata[8*g +: 8];
            if (capture)
                rd_q <= mem[widx];
        end
        assign rd_word[8*g +: 8] = rd_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            type_q  <= '0;
            led     <= 6'b111111;
        end else begin
            valid_q <= capture & is_rd;
            if (capture) begin
                addr_q <= address;
                type_q <= read_type;
            end
            if (capture && is_wr && is_led)
                led <= ~data_in[5:0];
        end
    end

    // IO values are already right-aligned, so lane selection applies to RAM data only.
    always_comb begin
        raw = rd_word;
        if (addr_q[31:4] == 28'hFFF_FFFF)
            raw = (addr_q == ADDR_LED) ? {26'b0, ~led} : 32'b0;
        else if (type_q[1:0] == RT_BYTE)
            raw = rd_word >> {addr_q[1:0], 3'b000};
        else if (type_q[1:0] == RT_HALF)
            raw = rd_word >> {addr_q[1], 4'b0000};
    end

    assign data_out       = valid_q ? extend_rd(raw, type_q) : 32'b0;
    assign data_out_ready = valid_q & enable & (address == addr_q) &
                            (read_type == type_q) & (write_type == WT_NONE);

    ram_io_uart_tx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE)
    ) u_uart (
        .clk  (clk),
        .rst_n(rst_n),
        .go   (uart_go),
        .data (data_in[7:0]),
        .tx   (uart_tx),
        .busy (uart_busy)
    );

endmodule

// File: tb/tb_ram_io.sv
// tb/tb_ram_io.sv - self-checking bench for ram_io: directed table, UART frame, random ops vs byte model
module tb_ram_io;

    localparam int AW        = 6;
    localparam int RAM_BYTES = 4 * (2 ** AW);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  write_type = '0;
    logic [2:0]  read_type = '0;
    logic [31:0] address = '0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        data_out_ready, busy, uart_tx;
    logic [5:0]  led;

    always #5 clk = ~clk;

    ram_io #(.RAM_ADDR_WIDTH(AW), .CLK_FREQ(8), .BAUD_RATE(1)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .write_type(write_type),
        .read_type(read_type), .address(address), .data_in(data_in),
        .data_out(data_out), .data_out_ready(data_out_ready), .busy(busy),
        .led(led), .uart_tx(uart_tx)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0] mem_m [RAM_BYTES];
    logic [5:0] led_on_m = '0;

    typedef struct {
        bit          is_wr;
        logic [1:0]  wt;
        logic [2:0]  rt;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int size_of(input logic [1:0] code);
        return (code == 2'd1) ? 1 : (code == 2'd2) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] rt, input logic [31:0] a);
        int n, base;
        logic [31:0] v, span;
        n = size_of(rt[1:0]);
        v = 0;
        if (a == 32'hFFFF_FFFF)
            v = {26'b0, led_on_m};
        else if (a < 32'hFFFF_FFF0) begin
            base = int'(a % 32'(RAM_BYTES));
            base = base - base % n;
            for (int i = 0; i < n; i++)
                v = v + (32'(mem_m[base + i]) << (8 * i));
        end
        if (n < 4) begin
            span = 32'h1 << (8 * n);
            v = v % span;
            if (rt[2] && v >= span / 2)
                v = v - span;
        end
        return v;
    endfunction

    task automatic model_write(input logic [1:0] wt, input logic [31:0] a, input logic [31:0] d);
        int n, base;
        if (a == 32'hFFFF_FFFF)
            led_on_m = d[5:0];
        else if (a < 32'hFFFF_FFF0) begin
            n = size_of(wt);
            base = int'(a % 32'(RAM_BYTES));
            base = base - base % n;
            for (int i = 0; i < n; i++)
                mem_m[base + i] = d[8*i +: 8];
        end
    endtask

    task automatic do_write(input logic [1:0] wt, input logic [31:0] a, input logic [31:0] d);
        enable = 1'b1; write_type = wt; read_type = 3'b000; address = a; data_in = d;
        @(posedge clk); #1;
        enable = 1'b0; write_type = 2'b00;
        model_write(wt, a, d);
    endtask

    task automatic do_read(input string name, input logic [2:0] rt, input logic [31:0] a,
                           input logic [31:0] exp);
        int n;
        enable = 1'b1; write_type = 2'b00; read_type = rt; address = a;
        #1;
        check({name, " ready_at_present"}, 32'(data_out_ready), 32'd0);
        n = 0;
        while (!data_out_ready && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, " latency"}, 32'(n), 32'd1);
        check({name, " data"}, data_out, exp);
        check({name, " busy"}, 32'(busy), 32'd0);
        enable = 1'b0; read_type = 3'b000;
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0]  frame;
        logic [31:0] a, d;
        logic [2:0]  rts [6];
        int busy_cycles, early, n;

        rts = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};

        repeat (2) @(posedge clk);
        #1;
        check("reset data_out", data_out, 32'd0);
        check("reset ready", 32'(data_out_ready), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset led", 32'(led), 32'h3F);
        check("reset uart_tx", 32'(uart_tx), 32'd1);
        rst_n = 1'b1;

        for (int w = 0; w < RAM_BYTES / 4; w++)
            do_write(2'd3, 32'(w * 4), $urandom);

        tbl.push_back('{1, 2'd3, 3'd0, 32'h10, 32'hDEADBEEF, 32'h0});
        tbl.push_back('{0, 2'd0, 3'd3, 32'h10, 32'h0, 32'hDEADBEEF});
        tbl.push_back('{1, 2'd1, 3'd0, 32'h11, 32'h80, 32'h0});
        tbl.push_back('{0, 2'd0, 3'd5, 32'h11, 32'h0, 32'hFFFFFF80});
        tbl.push_back('{0, 2'd0, 3'd1, 32'h11, 32'h0, 32'h00000080});
        tbl.push_back('{0, 2'd0, 3'd3, 32'h10, 32'h0, 32'hDEAD80EF});
        tbl.push_back('{1, 2'd2, 3'd0, 32'h12, 32'h8001, 32'h0});
        tbl.push_back('{0, 2'd0, 3'd6, 32'h12, 32'h0, 32'hFFFF8001});
        tbl.push_back('{0, 2'd0, 3'd2, 32'h13, 32'h0, 32'h00008001});
        tbl.push_back('{0, 2'd0, 3'd7, 32'h10, 32'h0, 32'h800180EF});
        tbl.push_back('{0, 2'd0, 3'd5, 32'h13, 32'h0, 32'hFFFFFF80});
        tbl.push_back('{1, 2'd3, 3'd0, 32'hFFFFFFFF, 32'h15, 32'h0});
        tbl.push_back('{0, 2'd0, 3'd3, 32'hFFFFFFFF, 32'h0, 32'h15});
        tbl.push_back('{0, 2'd0, 3'd5, 32'hFFFFFFFF, 32'h0, 32'h15});
        tbl.push_back('{1, 2'd3, 3'd0, 32'hFFFFFFF4, 32'h12345678, 32'h0});
        tbl.push_back('{0, 2'd0, 3'd3, 32'hFFFFFFF4, 32'h0, 32'h0});
        tbl.push_back('{0, 2'd0, 3'd3, 32'hFFFFFFFE, 32'h0, 32'h0});
        tbl.push_back('{1, 2'd3, 3'd0, 32'h104, 32'hCAFEF00D, 32'h0});
        tbl.push_back('{0, 2'd0, 3'd3, 32'h4, 32'h0, 32'hCAFEF00D});
        tbl.push_back('{1, 2'd2, 3'd0, 32'h7, 32'hABCD, 32'h0});
        tbl.push_back('{0, 2'd0, 3'd3, 32'h4, 32'h0, 32'hABCDF00D});

        foreach (tbl[i]) begin
            if (tbl[i].is_wr)
                do_write(tbl[i].wt, tbl[i].addr, tbl[i].data);
            else
                do_read($sformatf("vec%0d", i), tbl[i].rt, tbl[i].addr, tbl[i].exp);
        end
        check("led after write 0x15", 32'(led), 32'b101010);

        // A changed request must not see the previous request's data.
        enable = 1'b1; read_type = 3'b110; address = 32'h12;
        @(posedge clk); #1;
        check("chg first ready", 32'(data_out_ready), 32'd1);
        check("chg first data", data_out, 32'hFFFF8001);
        read_type = 3'b011; address = 32'h10;
        #1;
        check("chg stale ready", 32'(data_out_ready), 32'd0);
        @(posedge clk); #1;
        check("chg second ready", 32'(data_out_ready), 32'd1);
        check("chg second data", data_out, 32'h800180EF);
        enable = 1'b0; read_type = 3'b000;
        @(posedge clk); #1;

        // UART frame for 0x41 with a RAM read held underneath it.
        enable = 1'b1; write_type = 2'd1; address = 32'hFFFF_FFFE; data_in = 32'h41;
        @(posedge clk); #1;
        write_type = 2'd0; read_type = 3'b011; address = 32'h10;
        frame = {1'b1, 8'h41, 1'b0};
        busy_cycles = 0;
        early = 0;
        while (busy && busy_cycles < 200) begin
            if (busy_cycles < 80)
                check($sformatf("uart bit%0d cyc%0d", busy_cycles / 8, busy_cycles),
                      32'(uart_tx), 32'(frame[busy_cycles / 8]));
            if (data_out_ready)
                early++;
            busy_cycles++;
            @(posedge clk); #1;
        end
        check("uart busy cycles", 32'(busy_cycles), 32'd80);
        check("read ready during frame", 32'(early), 32'd0);
        n = 0;
        while (!data_out_ready && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        check("stalled read latency", 32'(n), 32'd1);
        check("stalled read data", data_out, 32'h800180EF);
        check("uart idle after frame", 32'(uart_tx), 32'd1);
        enable = 1'b0; read_type = 3'b000;
        @(posedge clk); #1;

        for (int i = 0; i < 200; i++) begin
            n = $urandom_range(0, 9);
            if (n == 0)      a = 32'hFFFF_FFFF;
            else if (n == 1) a = 32'hFFFF_FFF0 + $urandom_range(0, 13);
            else             a = $urandom_range(0, 1023);
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                do_write(2'($urandom_range(1, 3)), a, d);
            end else begin
                read_type = rts[$urandom_range(0, 5)];
                do_read($sformatf("rnd%0d", i), read_type, a, model_read(read_type, a));
            end
        end

        // Reset with a read result pending.
        enable = 1'b1; read_type = 3'b011; address = 32'h10;
        @(posedge clk); #1;
        check("pending ready before reset", 32'(data_out_ready), 32'd1);
        rst_n = 1'b0;
        #1;
        check("pending ready in reset", 32'(data_out_ready), 32'd0);
        enable = 1'b0; read_type = 3'b000;
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_write(2'd3, 32'hFFFF_FFFF, 32'h2A);

        // Reset in the middle of a UART frame.
        enable = 1'b1; write_type = 2'd1; address = 32'hFFFF_FFFE; data_in = 32'h55;
        @(posedge clk); #1;
        write_type = 2'd0; read_type = 3'b011; address = 32'h10;
        repeat (20) @(posedge clk);
        #1;
        check("busy mid frame", 32'(busy), 32'd1);
        rst_n = 1'b0;
        led_on_m = '0;
        #1;
        check("reset uart_tx", 32'(uart_tx), 32'd1);
        check("reset busy mid frame", 32'(busy), 32'd0);
        check("reset ready mid frame", 32'(data_out_ready), 32'd0);
        check("reset led mid frame", 32'(led), 32'h3F);
        enable = 1'b0; read_type = 3'b000;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("uart idle after reset", 32'(uart_tx), 32'd1);
        do_read("post reset word", 3'b011, 32'h10, model_read(3'b011, 32'h10));
        do_read("post reset led", 3'b011, 32'hFFFF_FFFF, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
